// File: rtl/adder_pkg.sv
// adder_pkg: shared types and width constants for the dual-adder result
// accumulator.
//   state_t     : batch FSM state (ACCUM collecting results, HOLD presenting one)
//   N_DEF/M_DEF : default lane sum widths, excluding the carry-out bit
//   K_DEF       : default log2 of the number of results per batch
//   acc_w()     : accumulator width for a lane: sum width + carry bit + K
package adder_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int N_DEF = 16;
    localparam int M_DEF = 8;
    localparam int K_DEF = 2;

    // Adding 2^k values of (base+1) bits needs k extra bits to never wrap.
    function automatic int acc_w(input int base, input int k);
        return base + 1 + k;
    endfunction

endpackage

// File: rtl/accum_lane.sv
// accum_lane: one widened accumulator for a single adder lane.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, zeroes the accumulator
//   add_en : add the zero-extended din this cycle
//   clr    : zero the accumulator this cycle (wins over add_en)
//   din    : W-bit unsigned lane result
//   acc    : W+K-bit running sum
module accum_lane
    import adder_pkg::*;
#(
    parameter int W = N_DEF + 1,
    parameter int K = K_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en,
    input  logic             clr,
    input  logic [W-1:0]     din,
    output logic [W+K-1:0]   acc
);

    // Running sum register; clear beats add so an aborted or consumed
    // batch never leaks into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + {{K{1'b0}}, din};
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/adder_result_accum.sv
// adder_result_accum: collects 2^K {S, T, overflow} results from the dual
// adder into widened per-lane sums and hands each finished batch downstream.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : upstream result handshake
//   S, T, ovf_in         : lane-1 sum (N+1), lane-2 sum (M+1), combined overflow
//   clear                : synchronous batch abort, highest priority
//   acc_s, acc_t         : lane accumulators (N+1+K, M+1+K bits)
//   ovf_sticky           : OR of ovf_in over accepted results of the batch
//   batch_cnt            : results accepted so far in the batch (mod 2^K)
//   out_valid / out_ready: downstream batch handshake
module adder_result_accum
    import adder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int K = K_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N:0]                S,
    input  logic [M:0]                T,
    input  logic                      ovf_in,
    input  logic                      clear,
    output logic [acc_w(N, K)-1:0]    acc_s,
    output logic [acc_w(M, K)-1:0]    acc_t,
    output logic                      ovf_sticky,
    output logic [K-1:0]              batch_cnt,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [K-1:0] LAST_CNT = {K{1'b1}};

    state_t state;
    logic   accept;
    logic   consume;
    logic   lane_clr;

    // in_ready must drop in the same cycle clear is raised, so it cannot be
    // a pure register; it is the registered state gated by clear.
    assign in_ready = (state == ACCUM) && !clear;
    assign accept   = in_valid && in_ready;
    assign consume  = (state == HOLD) && out_ready;
    assign lane_clr = clear || consume;

    accum_lane #(.W(N + 1), .K(K)) u_lane_s (
        .clk    (clk),
        .rst    (rst),
        .add_en (accept),
        .clr    (lane_clr),
        .din    (S),
        .acc    (acc_s)
    );

    accum_lane #(.W(M + 1), .K(K)) u_lane_t (
        .clk    (clk),
        .rst    (rst),
        .add_en (accept),
        .clr    (lane_clr),
        .din    (T),
        .acc    (acc_t)
    );

    // Batch FSM with counter, sticky overflow and registered out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            batch_cnt  <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            state      <= ACCUM;
            batch_cnt  <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        // Counter wraps to 0 on the final accept, so HOLD shows 0.
                        batch_cnt  <= batch_cnt + K'(1);
                        ovf_sticky <= ovf_sticky | ovf_in;
                        if (batch_cnt == LAST_CNT) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state     <= ACCUM;
                            out_valid <= 1'b0;
                        end
                    end else begin
                        state      <= ACCUM;
                        batch_cnt  <= batch_cnt;
                        ovf_sticky <= ovf_sticky;
                        out_valid  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= ACCUM;
                        ovf_sticky <= 1'b0;
                        out_valid  <= 1'b0;
                    end else begin
                        state      <= HOLD;
                        ovf_sticky <= ovf_sticky;
                        out_valid  <= 1'b1;
                    end
                    batch_cnt <= batch_cnt;
                end
                default: begin
                    state      <= ACCUM;
                    batch_cnt  <= '0;
                    ovf_sticky <= 1'b0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_result_accum.sv
module tb_adder_result_accum;

    localparam int N = 16;
    localparam int M = 8;
    localparam int K = 2;
    localparam int BATCH = 1 << K;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N:0]        S;
    logic [M:0]        T;
    logic              ovf_in;
    logic              clear;
    logic [N+K:0]      acc_s;
    logic [M+K:0]      acc_t;
    logic              ovf_sticky;
    logic [K-1:0]      batch_cnt;
    logic              out_valid;
    logic              out_ready;

    int vectors = 0;
    int miscompares = 0;

    adder_result_accum #(.N(N), .M(M), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .S          (S),
        .T          (T),
        .ovf_in     (ovf_in),
        .clear      (clear),
        .acc_s      (acc_s),
        .acc_t      (acc_t),
        .ovf_sticky (ovf_sticky),
        .batch_cnt  (batch_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the current batch is just the list of accepted results.
    typedef struct {
        longint s;
        longint t;
        bit     o;
    } res_t;

    res_t q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (clear) begin
            q.delete();
        end else if (q.size() == BATCH) begin
            if (out_ready) q.delete();
        end else if (in_valid) begin
            q.push_back(res_t'{longint'(S), longint'(T), ovf_in});
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        longint es;
        longint et;
        bit     eo;
        bit     full;
        es = 0;
        et = 0;
        eo = 1'b0;
        foreach (q[i]) begin
            es += q[i].s;
            et += q[i].t;
            eo |= q[i].o;
        end
        full = (q.size() == BATCH);
        check("model_acc_s", longint'(acc_s), es);
        check("model_acc_t", longint'(acc_t), et);
        check("model_ovf", longint'(ovf_sticky), longint'(eo));
        check("model_cnt", longint'(batch_cnt), longint'(q.size() % BATCH));
        check("model_out_valid", longint'(out_valid), longint'(full));
        check("model_in_ready", longint'(in_ready), longint'(!full && !clear));
    end

    // Apply inputs for one cycle; returns 1 time unit after the next rising edge.
    task automatic drive(input bit iv, input int s, input int t, input bit o,
                         input bit clr, input bit ordy);
        in_valid  = iv;
        S         = (N+1)'(s);
        T         = (M+1)'(t);
        ovf_in    = o;
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 0, 0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        int gap;
        rst = 1'b1;
        in_valid = 1'b0; S = '0; T = '0; ovf_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);

        // Reset mid-batch
        drive(1'b1, 5, 3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 6, 4, 1'b0, 1'b0, 1'b0);
        check("t1_pre_acc_s", longint'(acc_s), 11);
        rst = 1'b1;
        #1;
        check("t1_acc_s", longint'(acc_s), 0);
        check("t1_acc_t", longint'(acc_t), 0);
        check("t1_cnt", longint'(batch_cnt), 0);
        check("t1_ovf", longint'(ovf_sticky), 0);
        check("t1_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t1_in_ready", longint'(in_ready), 1);

        // Maximum values, back to back
        repeat (BATCH) drive(1'b1, 'h1FFFF, 'h1FF, 1'b0, 1'b0, 1'b0);
        check("t2_out_valid", longint'(out_valid), 1);
        check("t2_acc_s", longint'(acc_s), 'h7FFFC);
        check("t2_acc_t", longint'(acc_t), 'h7FC);
        check("t2_ovf", longint'(ovf_sticky), 0);
        check("t2_in_ready", longint'(in_ready), 0);
        check("t2_cnt", longint'(batch_cnt), 0);
        idle(1'b1);
        check("t2_rel_out_valid", longint'(out_valid), 0);
        check("t2_rel_acc_s", longint'(acc_s), 0);
        check("t2_rel_in_ready", longint'(in_ready), 1);

        // HOLD stability with in_valid pulses
        for (int i = 1; i <= 4; i++) drive(1'b1, i, i + 4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(i[0] == 1'b0, 99, 99, 1'b1, 1'b0, 1'b0);
            check("t3_hold_acc_s", longint'(acc_s), 10);
            check("t3_hold_acc_t", longint'(acc_t), 26);
            check("t3_hold_valid", longint'(out_valid), 1);
            check("t3_hold_ovf", longint'(ovf_sticky), 0);
        end
        idle(1'b1);
        check("t3_rel_valid", longint'(out_valid), 0);
        check("t3_rel_acc_t", longint'(acc_t), 0);
        check("t3_rel_in_ready", longint'(in_ready), 1);

        // Sticky overflow on the second result only
        drive(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        check("t4_ovf_first", longint'(ovf_sticky), 0);
        drive(1'b1, 1, 1, 1'b1, 1'b0, 1'b0);
        check("t4_ovf_second", longint'(ovf_sticky), 1);
        drive(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        check("t4_ovf_hold", longint'(ovf_sticky), 1);
        idle(1'b0);
        check("t4_ovf_hold2", longint'(ovf_sticky), 1);
        idle(1'b1);
        check("t4_ovf_rel", longint'(ovf_sticky), 0);

        // clear coincident with the third result
        drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1, 2, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; S = 17'd100; clear = 1'b1;
        #1;
        check("t5_in_ready_clr", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        check("t5_acc_s", longint'(acc_s), 0);
        check("t5_cnt", longint'(batch_cnt), 0);
        check("t5_ovf", longint'(ovf_sticky), 0);
        repeat (BATCH) drive(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
        check("t5_acc_s_after", longint'(acc_s), 4);
        check("t5_valid_after", longint'(out_valid), 1);
        idle(1'b1);

        // Gapped results
        for (int i = 0; i < BATCH; i++) begin
            drive(1'b1, 7, 1, 1'b0, 1'b0, 1'b0);
            gap = (i == BATCH - 1) ? 0 : int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) idle(1'b0);
        end
        check("t6_valid", longint'(out_valid), 1);
        check("t6_acc_s", longint'(acc_s), 28);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(99, 0) == 0);
            drive($urandom_range(9, 0) < 7,
                  int'($urandom_range(17'h1FFFF, 0)),
                  int'($urandom_range(9'h1FF, 0)),
                  $urandom_range(3, 0) == 0,
                  $urandom_range(19, 0) == 0,
                  $urandom_range(9, 0) < 4);
        end
        rst = 1'b0;
        idle(1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_result_accum.md
Name: adder_result_accum

Overview:
- Sequential stage directly downstream of the hierarchical dual adder (16-bit and 8-bit lanes with carry-out and combined overflow).
- Captures each {S, T, overflow} result under a valid/ready handshake and accumulates 2^K results per batch into widened sums.
- Keeps a sticky overflow flag and presents each finished batch on an output valid/ready handshake.

Parameters:
- N, 16: width of lane-1 sum without carry; input S is N+1 bits.
- M, 8: width of lane-2 sum without carry; input T is M+1 bits.
- K, 2: log2 of results per batch; K >= 1 (default batch of 4).

Ports:
- Clock, input, 1: single clock; all state updates on the rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: upstream result valid.
- in_ready, output, 1: block can accept a result this cycle.
- S, input, N+1: lane-1 sum including carry-out (unsigned).
- T, input, M+1: lane-2 sum including carry-out (unsigned).
- ovf_in, input, 1: combined overflow from the adder stage.
- clear, input, 1: synchronous batch abort.
- acc_s, output, N+1+K: lane-1 batch accumulator.
- acc_t, output, M+1+K: lane-2 batch accumulator.
- ovf_sticky, output, 1: OR of ovf_in over accepted results in the current batch.
- batch_cnt, output, K: count of results accepted in the current batch.
- out_valid, output, 1: batch complete; outputs stable.
- out_ready, input, 1: downstream consumes the batch.

Behaviour:
- Reset (asynchronous, Reset=1):
  - State goes to ACCUM.
  - acc_s, acc_t, ovf_sticky, batch_cnt and out_valid all go to 0.
  - in_ready is 1 on the first cycle after Reset deasserts.
- States:
  - ACCUM: in_ready = ~clear; out_valid = 0.
  - HOLD: in_ready = 0; out_valid = 1.
- Accept means in_valid & in_ready at a rising edge. On accept:
  - acc_s <= acc_s + zero-extended S.
  - acc_t <= acc_t + zero-extended T.
  - ovf_sticky <= ovf_sticky | ovf_in.
  - batch_cnt <= batch_cnt + 1 (wraps modulo 2^K).
- ACCUM -> HOLD: on an accept while batch_cnt == 2^K-1.
  - out_valid rises the cycle after the final accept (latency 1).
  - batch_cnt shows 0 in HOLD.
- HOLD -> ACCUM: on out_ready.
  - The next cycle has acc_s, acc_t and ovf_sticky at 0 and in_ready at 1.
  - Outputs are held stable while out_valid=1 and out_ready=0, for any number of cycles.
- Width rule: the accumulators cannot wrap. The maximum is 2^K * (2^(N+1)-1) < 2^(N+1+K), and likewise for T. No saturation logic is needed.
- clear (any state): highest priority.
  - Next cycle: state ACCUM, accumulators, ovf_sticky and batch_cnt at 0, out_valid 0.
  - A coincident in_valid is not accepted, because in_ready=0 while clear=1.
  - A coincident out_ready is ignored and the batch is discarded.
- in_valid while in HOLD is ignored; upstream must hold its data until in_ready.
- ovf_in is sampled only on accept.
- Idle cycles (in_valid=0) leave all state unchanged.
- Reset asserted mid-batch or in HOLD: immediate return to reset values; the partial batch is discarded.

Decomposition:
- Shared package adder_pkg holds:
  - State typedef {ACCUM, HOLD}.
  - Default width constants N=16, M=8, K=2.
  - Derived width helpers (N+1+K, M+1+K).
- One natural sub-module, accum_lane, instantiated once per lane.
  - Parameters: input width W and extension K.
  - Ports: Clock, Reset, add_en, clr, din[W-1:0], acc[W+K-1:0].
- The top level holds the FSM, batch counter, sticky flag and handshake logic.

Test Plan:
1. Reset mid-batch after 2 accepts -> acc_s=0, acc_t=0, batch_cnt=0, ovf_sticky=0, out_valid=0; in_ready=1 after release.
2. Four back-to-back accepts of S=17'h1FFFF, T=9'h1FF, ovf_in=0 -> the cycle after the 4th accept: out_valid=1, acc_s=19'h7FFFC, acc_t=11'h7FC, ovf_sticky=0, in_ready=0.
3. Batch S={1,2,3,4}, T={5,6,7,8} with out_ready low for 5 cycles and in_valid pulsed in HOLD:
   - acc_s=10 and acc_t=26 stay stable; pulses are not accepted.
   - out_ready=1 -> next cycle out_valid=0, accumulators 0, in_ready=1.
4. ovf_in=1 only on the 2nd of 4 results -> ovf_sticky=1 from the cycle after that accept through HOLD; 0 after the out_ready handshake.
5. clear=1 coincident with in_valid on the 3rd result (S=100) -> no accept; next cycle acc_s=0, batch_cnt=0. A following 4 results of S=1 give acc_s=4.
6. Four results of S=7 separated by 0-3 idle cycles -> acc_s=28, out_valid exactly one cycle after the 4th accept, same as back-to-back.
